vec_issue_sequencer: RTL and testbench

- Sits between the scalar processor's valid/ready interface and the vector datapath.
- Accepts instruction/rs1/rs2 bundles into a DEPTH-entry FIFO and issues them to the datapath strictly one at a time.
- Holds each issued bundle stable until the datapath reports completion, then returns an acknowledge (with error flag) to the scalar processor.
- Replaces ad-hoc queue/val-ready glue with one sequenced issue controller.

---
 rtl/vec_issue_sequencer.sv | 110 +++++++++++
 tb/tb_vec_issue_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_sequencer.sv
// rtl/vec_issue_sequencer.sv - queues scalar instruction bundles and issues them one at a time to the vector datapath
module vec_issue_sequencer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_valid,
  input  logic [XLEN-1:0]            instruction,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  output logic                       vec_pro_ready,
  output logic                       issue_valid,
  output logic [XLEN-1:0]            issue_instruction,
  output logic [XLEN-1:0]            issue_rs1_data,
  output logic [XLEN-1:0]            issue_rs2_data,
  input  logic                       is_vec,
  input  logic                       inst_done,
  input  logic                       scalar_pro_ready,
  output logic                       vec_pro_ack,
  output logic                       vec_pro_err,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] rs1_mem  [DEPTH];
  logic [XLEN-1:0] rs2_mem  [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  state_t          state;
  logic            full;
  logic            push;
  logic            pop;

  assign full          = (count == CW'(DEPTH));
  assign vec_pro_ready = !full && !reset;
  assign push          = inst_valid && vec_pro_ready;
  // The FIFO is only drained on the IDLE->EXEC transition.
  assign pop           = (state == IDLE) && (count != '0);
  assign busy          = (state != IDLE);
  assign fifo_count    = count;

  // Storage is not reset: a cleared count already makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= instruction;
      rs1_mem[wr_ptr]  <= rs1_data;
      rs2_mem[wr_ptr]  <= rs2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      state             <= IDLE;
      issue_valid       <= 1'b0;
      issue_instruction <= '0;
      issue_rs1_data    <= '0;
      issue_rs2_data    <= '0;
      vec_pro_ack       <= 1'b0;
      vec_pro_err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      issue_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            issue_instruction <= inst_mem[rd_ptr];
            issue_rs1_data    <= rs1_mem[rd_ptr];
            issue_rs2_data    <= rs2_mem[rd_ptr];
            issue_valid       <= 1'b1;
            state             <= EXEC;
          end
        end
        EXEC: begin
          // Illegality wins over a coincident completion.
          if (!is_vec) begin
            vec_pro_ack <= 1'b1;
            vec_pro_err <= 1'b1;
            state       <= ACK;
          end else if (inst_done) begin
            vec_pro_ack <= 1'b1;
            vec_pro_err <= 1'b0;
            state       <= ACK;
          end
        end
        ACK: begin
          if (scalar_pro_ready) begin
            vec_pro_ack <= 1'b0;
            vec_pro_err <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_issue_sequencer.sv
// tb/tb_vec_issue_sequencer.sv - directed self-checking bench for vec_issue_sequencer
module tb_vec_issue_sequencer;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  logic inst_valid;
  logic [XLEN-1:0] instruction, rs1_data, rs2_data;
  logic vec_pro_ready, issue_valid;
  logic [XLEN-1:0] issue_instruction, issue_rs1_data, issue_rs2_data;
  logic is_vec, inst_done, scalar_pro_ready;
  logic vec_pro_ack, vec_pro_err, busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int total = 0;
  int bad = 0;

  vec_issue_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .vec_pro_ready(vec_pro_ready),
    .issue_valid(issue_valid), .issue_instruction(issue_instruction),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .is_vec(is_vec), .inst_done(inst_done), .scalar_pro_ready(scalar_pro_ready),
    .vec_pro_ack(vec_pro_ack), .vec_pro_err(vec_pro_err), .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    inst_valid = v; instruction = i; rs1_data = a; rs2_data = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, '0, '0);
    is_vec = 1'b1; inst_done = 1'b0; scalar_pro_ready = 1'b0;
    step(); step();
    total++; if (vec_pro_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", vec_pro_ready); end
    total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    total++; if ({issue_valid, vec_pro_ack, vec_pro_err, busy} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {issue_valid, vec_pro_ack, vec_pro_err, busy}); end
    total++; if (issue_instruction !== 32'h0) begin bad++; $display("FAIL reset_issue_inst got=%h exp=0", issue_instruction); end
    reset = 1'b0;
    step();
    total++; if (vec_pro_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", vec_pro_ready); end
    total++; if ({issue_valid, busy, fifo_count} !== 4'b0) begin bad++; $display("FAIL post_reset_state got=%b exp=0000", {issue_valid, busy, fifo_count}); end
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0200_7057, 32'd8, 32'd0);
    step();
    drive(1'b0, '0, '0, '0);
    total++; if (fifo_count !== 2'd1 || issue_valid !== 1'b0) begin bad++; $display("FAIL single_queued got=%0d/%b exp=1/0", fifo_count, issue_valid); end
    step();
    total++; if (issue_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_issue got=%b/%b exp=1/1", issue_valid, busy); end
    total++; if ({issue_instruction, issue_rs1_data, issue_rs2_data} !== {32'h0200_7057, 32'd8, 32'd0})
      begin bad++; $display("FAIL single_data got=%h %h %h exp=02007057 8 0", issue_instruction, issue_rs1_data, issue_rs2_data); end
    total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL single_popped got=%0d exp=0", fifo_count); end
    step();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", issue_valid); end
    step(); step();
    total++; if (vec_pro_ack !== 1'b0 || issue_instruction !== 32'h0200_7057) begin bad++; $display("FAIL single_hold got=%b %h exp=0 02007057", vec_pro_ack, issue_instruction); end
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    total++; if (vec_pro_ack !== 1'b1 || vec_pro_err !== 1'b0) begin bad++; $display("FAIL single_ack got=%b/%b exp=1/0", vec_pro_ack, vec_pro_err); end
    scalar_pro_ready = 1'b1;
    step();
    scalar_pro_ready = 1'b0;
    total++; if (vec_pro_ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_ack_clear got=%b/%b exp=0/0", vec_pro_ack, busy); end
    total++; if (issue_instruction !== 32'h0200_7057) begin bad++; $display("FAIL single_retain got=%h exp=02007057", issue_instruction); end
  endtask

  task automatic test_full();
    logic [XLEN-1:0] got[$];
    logic [XLEN-1:0] exp_order[4];
    exp_order[0] = 32'hA0; exp_order[1] = 32'hB1; exp_order[2] = 32'hC2; exp_order[3] = 32'hD3;
    drive(1'b1, 32'hA0, 32'h1, 32'h2);
    step();
    drive(1'b1, 32'hB1, 32'h3, 32'h4);
    step();
    if (issue_valid === 1'b1) got.push_back(issue_instruction);
    drive(1'b1, 32'hC2, 32'h5, 32'h6);
    step();
    drive(1'b1, 32'hD3, 32'h7, 32'h8);
    total++; if (fifo_count !== 2'd2 || vec_pro_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=2/0", fifo_count, vec_pro_ready); end
    step();
    total++; if (fifo_count !== 2'd2) begin bad++; $display("FAIL full_stall got=%0d exp=2", fifo_count); end
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    scalar_pro_ready = 1'b1;
    step();
    scalar_pro_ready = 1'b0;
    step();
    total++; if (vec_pro_ready !== 1'b1 || issue_valid !== 1'b1) begin bad++; $display("FAIL full_slot_free got=%b/%b exp=1/1", vec_pro_ready, issue_valid); end
    for (int i = 0; i < 60 && got.size() < 4; i++) begin
      if (i == 1) drive(1'b0, '0, '0, '0);
      if (i == 1) begin
        total++; if (fifo_count !== 2'd2) begin bad++; $display("FAIL full_d_accepted got=%0d exp=2", fifo_count); end
      end
      scalar_pro_ready = 1'b1;
      if (issue_valid === 1'b1) begin
        got.push_back(issue_instruction);
        inst_done = 1'b1;
      end else begin
        inst_done = 1'b0;
      end
      step();
    end
    inst_done = 1'b0;
    for (int i = 0; i < 10 && busy === 1'b1; i++) step();
    scalar_pro_ready = 1'b0;
    total++; if (got.size() != 4) begin bad++; $display("FAIL full_issue_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== exp_order[i]) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, got[i], exp_order[i]); end
      end
    end
    total++; if (busy !== 1'b0 || fifo_count !== 2'd0) begin bad++; $display("FAIL full_drained got=%b/%0d exp=0/0", busy, fifo_count); end
  endtask

  task automatic test_simul();
    drive(1'b1, 32'h1111, 32'h0, 32'h0);
    step();
    drive(1'b1, 32'h2222, 32'h0, 32'h0);
    total++; if (fifo_count !== 2'd1 || busy !== 1'b0) begin bad++; $display("FAIL simul_pre got=%0d/%b exp=1/0", fifo_count, busy); end
    step();
    drive(1'b0, '0, '0, '0);
    total++; if (fifo_count !== 2'd1) begin bad++; $display("FAIL simul_count got=%0d exp=1", fifo_count); end
    total++; if (issue_valid !== 1'b1 || issue_instruction !== 32'h1111) begin bad++; $display("FAIL simul_first got=%b %h exp=1 00001111", issue_valid, issue_instruction); end
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    total++; if (vec_pro_ack !== 1'b1) begin bad++; $display("FAIL simul_done_with_issue got=%b exp=1", vec_pro_ack); end
    scalar_pro_ready = 1'b1;
    step();
    scalar_pro_ready = 1'b0;
    step();
    total++; if (issue_valid !== 1'b1 || issue_instruction !== 32'h2222) begin bad++; $display("FAIL simul_second got=%b %h exp=1 00002222", issue_valid, issue_instruction); end
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    scalar_pro_ready = 1'b1;
    step();
    scalar_pro_ready = 1'b0;
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'hDEAD_0001, 32'h0, 32'h0);
    step();
    drive(1'b0, '0, '0, '0);
    step();
    step();
    is_vec = 1'b0;
    step();
    is_vec = 1'b1;
    total++; if (vec_pro_ack !== 1'b1 || vec_pro_err !== 1'b1) begin bad++; $display("FAIL illegal_ack got=%b/%b exp=1/1", vec_pro_ack, vec_pro_err); end
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    total++; if (vec_pro_err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL illegal_done_ignored got=%b/%b exp=1/1", vec_pro_err, busy); end
    scalar_pro_ready = 1'b1;
    step();
    scalar_pro_ready = 1'b0;
    total++; if ({vec_pro_ack, vec_pro_err, busy} !== 3'b000) begin bad++; $display("FAIL illegal_clear got=%b exp=000", {vec_pro_ack, vec_pro_err, busy}); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h5050, 32'h0, 32'h0);
    step();
    drive(1'b1, 32'h6060, 32'h0, 32'h0);
    step();
    drive(1'b0, '0, '0, '0);
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (vec_pro_ack !== 1'b1 || issue_valid !== 1'b0 || fifo_count !== 2'd1)
        begin bad++; $display("FAIL bp_hold[%0d] got=%b/%b/%0d exp=1/0/1", i, vec_pro_ack, issue_valid, fifo_count); end
      step();
    end
    scalar_pro_ready = 1'b1;
    step();
    scalar_pro_ready = 1'b0;
    total++; if (vec_pro_ack !== 1'b0 || issue_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b exp=0/0", vec_pro_ack, issue_valid); end
    step();
    total++; if (issue_valid !== 1'b1 || issue_instruction !== 32'h6060) begin bad++; $display("FAIL bp_next_issue got=%b %h exp=1 00006060", issue_valid, issue_instruction); end
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    scalar_pro_ready = 1'b1;
    step();
    scalar_pro_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h7001, 32'h0, 32'h0);
    step();
    drive(1'b1, 32'h7002, 32'h0, 32'h0);
    step();
    drive(1'b1, 32'h7003, 32'h0, 32'h0);
    step();
    drive(1'b0, '0, '0, '0);
    total++; if (fifo_count !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%0d/%b exp=2/1", fifo_count, busy); end
    reset = 1'b1;
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    total++; if ({fifo_count, busy, vec_pro_ack, issue_valid, vec_pro_ready} !== 6'b0)
      begin bad++; $display("FAIL rmid_cleared got=%0d %b%b%b%b exp=0 0000", fifo_count, busy, vec_pro_ack, issue_valid, vec_pro_ready); end
    reset = 1'b0;
    step();
    total++; if (vec_pro_ready !== 1'b1 || fifo_count !== 2'd0) begin bad++; $display("FAIL rmid_after got=%b/%0d exp=1/0", vec_pro_ready, fifo_count); end
    for (int i = 0; i < 4; i++) begin
      total++; if (issue_valid !== 1'b0 || busy !== 1'b0 || vec_pro_ack !== 1'b0)
        begin bad++; $display("FAIL rmid_quiet[%0d] got=%b%b%b exp=000", i, issue_valid, busy, vec_pro_ack); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_simul();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
